// File: rtl/mem_stage_bus_ctrl_if.sv
// Data-memory bus between the M-stage controller (master) and the memory (slave).
// A request stays up until the slave returns a one-cycle bus_ready strobe.
interface mem_stage_bus_ctrl_if #(
  parameter int DATA_BITS = 32
);
  logic                 bus_req;
  logic                 bus_we;
  logic [DATA_BITS-1:0] bus_addr;
  logic [DATA_BITS-1:0] bus_wdata;
  logic                 bus_ready;
  logic [DATA_BITS-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_stage_bus_ctrl.sv
// Memory-stage bus master: stalls EX/MEM while a load/store runs on the data bus.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the bus and pulse misalign_m.
module mem_stage_bus_ctrl #(
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 mem_write_m,
  input  logic                 mem_to_reg_m,
  input  logic [DATA_BITS-1:0] alu_out_m,
  input  logic [DATA_BITS-1:0] write_data_m,
  output logic                 stall_m,
  output logic [DATA_BITS-1:0] read_data_m,
  output logic                 bus_timeout,
  output logic                 misalign_m,
  output logic [1:0]           dbg_state,
  mem_stage_bus_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t               state_q, state_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [DATA_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 timeout_q, timeout_d;
  logic                 misalign_q, misalign_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 access;
  logic                 misaligned;

  assign access = mem_write_m | mem_to_reg_m;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = |alu_out_m[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    timeout_d  = timeout_q;
    misalign_d = 1'b0;
    cnt_d      = cnt_q;
    stall_m    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall_m = access;
        if (access && misaligned) begin
          misalign_d = 1'b1;
          state_d    = ST_DONE;
        end else if (access) begin
          addr_d  = alu_out_m;
          wdata_d = write_data_m;
          we_d    = mem_write_m;
          req_d   = 1'b1;
          cnt_d   = 8'd0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_m = 1'b1;
        // Completion takes priority over a timeout landing on the same cycle.
        if (bus.bus_ready) begin
          if (!we_q) rdata_d = bus.bus_rdata;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          if (!we_q) rdata_d = '0;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        // One non-stalled cycle lets EX/MEM advance so the access is not re-issued.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      timeout_q  <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      timeout_q  <= timeout_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign read_data_m   = rdata_q;
  assign bus_timeout   = timeout_q;
  assign misalign_m    = misalign_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/mem_stage_bus_ctrl.md
Name: mem_stage_bus_ctrl

Overview:
Memory-stage bus master on the consumer side of the EX/MEM pipeline register. It accepts the M-stage control and data signals (mem_write_m, mem_to_reg_m, alu_out_m, write_data_m) and runs a req/ready handshake to the data-memory bus. It also drives stall_m back to the EX/MEM register, holding that register stable until the access completes. It returns read_data_m to the MEM/WB path.

Parameters:
DATA_BITS, 32, width of address and data (matches PC_BITS)
TIMEOUT_CYCLES, 255, maximum BUSY cycles before the access is abandoned; valid range 1 to 255

Ports:
clk  in  1  clock
clr  in  1  reset, asynchronous, active-high
mem_write_m  in  1  store in M stage
mem_to_reg_m  in  1  load in M stage
alu_out_m  in  DATA_BITS  effective address
write_data_m  in  DATA_BITS  store data
stall_m  out  1  hold for the EX/MEM register (combinational)
read_data_m  out  DATA_BITS  load result, registered
bus_req  out  1  bus request, registered
bus_we  out  1  1 = write, registered
bus_addr  out  DATA_BITS  registered address
bus_wdata  out  DATA_BITS  registered write data
bus_ready  in  1  bus completion strobe
bus_rdata  in  DATA_BITS  bus read data, sampled when bus_ready=1
bus_timeout  out  1  sticky flag, set on timeout
misalign_m  out  1  one-cycle misalignment pulse (see Optional Feature)

Behaviour:
- Reset (clr=1, async): state=IDLE. bus_req, bus_we, bus_addr, bus_wdata, read_data_m, bus_timeout, misalign_m and the timeout counter are all 0. stall_m=0.
- Access condition: access = mem_write_m | mem_to_reg_m. If both inputs are 1, the access is a write; read_data_m is not updated.
- IDLE:
  - stall_m = access.
  - On access: capture alu_out_m into bus_addr, write_data_m into bus_wdata and mem_write_m into bus_we. Set bus_req=1, clear the counter, go to BUSY.
  - No access: stay in IDLE with bus_req=0.
- BUSY:
  - stall_m=1, bus_req=1, and bus_addr/bus_wdata/bus_we are held.
  - bus_ready=1 completes the access. On a read, bus_rdata is captured into read_data_m. Then bus_req goes to 0 and the state goes to DONE.
  - On a cycle with bus_ready=0, the counter increments. The check is made on the cycle that counter == TIMEOUT_CYCLES-1 with bus_ready=0:
    - set bus_timeout;
    - on a read, set read_data_m=0;
    - set bus_req=0 and go to DONE.
  - If bus_ready=1 arrives on that same cycle, completion wins and no timeout is raised.
- DONE:
  - stall_m=0 and bus_req=0. The EX/MEM register advances at this edge. Next state is IDLE unconditionally.
  - DONE prevents the same stalled instruction from being re-issued.
- Timing:
  - Zero-wait access: stall_m is high for 2 cycles (IDLE, BUSY) and the result is visible in the DONE cycle. Minimum 3 cycles per access.
  - N wait cycles add N stall cycles.
- read_data_m holds its value until the next completed read, a timeout on a read, or reset.
- bus_ready is ignored in IDLE and DONE.
- bus_timeout is cleared only by clr.
- clr during BUSY aborts the access. bus_req falls asynchronously and no read data is captured.
- Non-access instructions pass through with stall_m=0 and no bus activity.

Optional Feature:
Macro: MISALIGN_TRAP_EN.
- Defined: in IDLE, an access with alu_out_m[1:0] != 0 issues no bus request. The block goes directly to DONE with misalign_m=1 for that DONE cycle. stall_m is high for the IDLE cycle only, and read_data_m is unchanged.
- Undefined: misalign_m is tied to 0. Misaligned addresses are issued to the bus unmodified.

Test Plan:
- Load, alu_out_m=0x100, mem_to_reg_m=1, bus_ready=1 in the first BUSY cycle, bus_rdata=0xDEADBEEF -> stall_m=1 for exactly 2 cycles, bus_addr=0x100, bus_we=0, read_data_m=0xDEADBEEF in the DONE cycle.
- Store, alu_out_m=0x200, write_data_m=0x12345678, bus_ready delayed 3 cycles -> bus_we=1, bus_wdata=0x12345678, stall_m high for 5 cycles, read_data_m unchanged.
- Back-to-back loads to 0x10 and 0x14 with zero wait -> exactly two bus_req pulses, 3 cycles apart, and no duplicate request for the stalled instruction.
- TIMEOUT_CYCLES=4, load with bus_ready never asserted -> bus_req high for 4 cycles, then bus_timeout=1, read_data_m=0, state returns to IDLE.
- clr pulsed in the second BUSY cycle -> bus_req=0 immediately, all outputs 0, next load runs normally.
- MISALIGN_TRAP_EN defined, load at 0x102 -> no bus_req, misalign_m pulses 1 cycle, stall_m high 1 cycle; with the macro undefined, bus_addr=0x102 is issued.
